// File: rtl/ama_riscv_pkg.sv
// ama_riscv_pkg: shared register-file constants and LU writeback payload type
package ama_riscv_pkg;
    localparam logic [4:0] RF_X0_ZERO = 5'd0;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } lu_wb_t;
endpackage

// File: rtl/ama_riscv_wb_arbiter_if.sv
// ama_riscv_wb_arbiter_if: writeback arbiter bus
// master (producers/decode/RF side): drives pipe_*, lu_issue*, lu_valid/rd/data, dec_*;
//   receives lu_ready, hazard, pipe_stall, rf_we/addr/data, err
// slave (arbiter): the mirror image
interface ama_riscv_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        err;
    modport master (
        output pipe_we, pipe_addr, pipe_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
               dec_rs1, dec_rs2, dec_rd,
        input  lu_ready, hazard, pipe_stall, rf_we, rf_addr, rf_data, err
    );
    modport slave (
        input  pipe_we, pipe_addr, pipe_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
               dec_rs1, dec_rs2, dec_rd,
        output lu_ready, hazard, pipe_stall, rf_we, rf_addr, rf_data, err
    );
endinterface

// File: rtl/ama_riscv_sync_fifo.sv
// ama_riscv_sync_fifo: synchronous FIFO, registered head (no fall-through)
// clk/rst: clock, sync active-high reset; push/din: write; pop/dout: read head
// full/empty: derived from the registered occupancy count
module ama_riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/ama_riscv_wb_arbiter.sv
// ama_riscv_wb_arbiter: merges pipeline writeback and buffered LU results onto the RF write port
// clk/rst: clock, sync active-high reset
// bus (slave): pipeline/LU/decode inputs; lu_ready, hazard, pipe_stall, rf_*, err outputs
module ama_riscv_wb_arbiter
    import ama_riscv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    ama_riscv_wb_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    lu_wb_t push_d, head;
    logic full, empty, push, pop, busy, pipe_sel, stall, err_flag, err_d;
    logic [31:0] pend, set_m, clr_m;
    logic [SW-1:0] starve_cnt;
    assign push_d = '{rd: bus.lu_rd, data: bus.lu_data};
    // x0 results are acknowledged but never buffered
    assign push = bus.lu_valid && !full && bus.lu_rd != RF_X0_ZERO;
    ama_riscv_sync_fifo #(.WIDTH($bits(lu_wb_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_d),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        stall = starve_cnt == SW'(STARVE_LIMIT);
        busy = bus.pipe_we && bus.pipe_addr != RF_X0_ZERO;
        pop = !empty && (stall || !busy);
        pipe_sel = !stall && busy;
        // pend bit 0 is never set, which masks x0 in the hazard lookup
        clr_m = pop ? 32'd1 << head.rd : '0;
        set_m = bus.lu_issue && bus.lu_issue_rd != RF_X0_ZERO ? 32'd1 << bus.lu_issue_rd : '0;
        err_d = (bus.pipe_we && stall) || (pop && !pend[head.rd]) || (pipe_sel && pend[bus.pipe_addr]);
    end
    assign bus.lu_ready = !full;
    assign bus.pipe_stall = stall;
    assign bus.rf_we = pop || pipe_sel;
    assign bus.rf_addr = pop ? head.rd : pipe_sel ? bus.pipe_addr : RF_X0_ZERO;
    assign bus.rf_data = pop ? head.data : pipe_sel ? bus.pipe_data : '0;
    assign bus.hazard = pend[bus.dec_rs1] || pend[bus.dec_rs2] || pend[bus.dec_rd];
    assign bus.err = err_flag;
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            starve_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            pend <= (pend & ~clr_m) | set_m;
            err_flag <= err_flag || err_d;
            starve_cnt <= pop ? '0 : (!empty && busy && !stall) ? starve_cnt + 1'b1 : starve_cnt;
        end
    end
endmodule

// File: tb/tb_ama_riscv_wb_arbiter.sv
// tb_ama_riscv_wb_arbiter: directed stimulus, queue-based reference model, per-cycle compare
module tb_ama_riscv_wb_arbiter;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_LIMIT = 4;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    ama_riscv_wb_arbiter_if bus();
    ama_riscv_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    bit [4:0]  q_rd[$];
    bit [31:0] q_data[$];
    bit        pend_m[32];
    int        starve_m = 0;
    bit        err_m = 0;
    logic        e_ready, e_hazard, e_stall, e_we, e_err, e_pop, e_busy;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    function automatic void model_outputs();
        e_busy = bus.pipe_we && bus.pipe_addr != 5'd0;
        e_stall = starve_m == STARVE_LIMIT;
        e_ready = q_rd.size() < FIFO_DEPTH;
        e_pop = q_rd.size() != 0 && (e_stall || !e_busy);
        e_we = e_pop || (e_busy && !e_stall);
        e_addr = e_pop ? q_rd[0] : e_we ? bus.pipe_addr : 5'd0;
        e_data = e_pop ? q_data[0] : e_we ? bus.pipe_data : 32'd0;
        e_hazard = (bus.dec_rs1 != 0 && pend_m[bus.dec_rs1]) || (bus.dec_rs2 != 0 && pend_m[bus.dec_rs2])
                || (bus.dec_rd != 0 && pend_m[bus.dec_rd]);
        e_err = err_m;
    endfunction

    task automatic model_step();
        int n;
        model_outputs();
        n = q_rd.size();
        if (rst) begin
            q_rd.delete();
            q_data.delete();
            foreach (pend_m[i]) pend_m[i] = 0;
            starve_m = 0;
            err_m = 0;
        end else begin
            if ((bus.pipe_we && e_stall) || (e_pop && !pend_m[q_rd[0]]) || (!e_pop && e_we && pend_m[bus.pipe_addr]))
                err_m = 1;
            if (e_pop) pend_m[q_rd[0]] = 0;
            if (bus.lu_issue && bus.lu_issue_rd != 0) pend_m[bus.lu_issue_rd] = 1;
            if (e_pop) starve_m = 0;
            else if (n > 0 && e_busy && starve_m < STARVE_LIMIT) starve_m++;
            if (e_pop) begin
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (bus.lu_valid && e_ready && bus.lu_rd != 0) begin
                q_rd.push_back(bus.lu_rd);
                q_data.push_back(bus.lu_data);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        #3;
        model_outputs();
        checks++;
        if (bus.lu_ready !== e_ready || bus.hazard !== e_hazard || bus.pipe_stall !== e_stall || bus.rf_we !== e_we
            || bus.err !== e_err || (e_we && (bus.rf_addr !== e_addr || bus.rf_data !== e_data))) begin
            errors++;
            $display("FAIL cycle t=%0t got rdy=%b haz=%b stall=%b we=%b addr=%0d data=%h err=%b exp rdy=%b haz=%b stall=%b we=%b addr=%0d data=%h err=%b",
                     $time, bus.lu_ready, bus.hazard, bus.pipe_stall, bus.rf_we, bus.rf_addr, bus.rf_data, bus.err,
                     e_ready, e_hazard, e_stall, e_we, e_addr, e_data, e_err);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic idle();
        bus.pipe_we = 0;
        bus.pipe_addr = 0;
        bus.pipe_data = 0;
        bus.lu_issue = 0;
        bus.lu_issue_rd = 0;
        bus.lu_valid = 0;
        bus.lu_rd = 0;
        bus.lu_data = 0;
        bus.dec_rs1 = 0;
        bus.dec_rs2 = 0;
        bus.dec_rd = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        @(negedge clk);
        idle();
        bus.lu_issue = 1;
        bus.lu_issue_rd = rd;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int idx;
        rst = 1;
        idle();
        repeat (2) @(negedge clk);
        rst = 0;
        #3;
        chk("reset_rf_we", 32'(bus.rf_we), 0);
        chk("reset_lu_ready", 32'(bus.lu_ready), 1);
        chk("reset_hazard", 32'(bus.hazard), 0);
        chk("reset_stall", 32'(bus.pipe_stall), 0);
        chk("reset_err", 32'(bus.err), 0);
        // pipeline-only, zero latency; x0 dropped
        @(negedge clk);
        bus.pipe_we = 1;
        bus.pipe_addr = 5;
        bus.pipe_data = 32'hDEADBEEF;
        #3;
        chk("pipe_we", 32'(bus.rf_we), 1);
        chk("pipe_addr", 32'(bus.rf_addr), 5);
        chk("pipe_data", bus.rf_data, 32'hDEADBEEF);
        @(negedge clk);
        bus.pipe_addr = 0;
        #3;
        chk("pipe_x0_we", 32'(bus.rf_we), 0);
        // LU round trip on rd=7
        issue(7);
        bus.dec_rs1 = 7;
        #3;
        chk("rt_haz_c0", 32'(bus.hazard), 0);
        @(negedge clk);
        bus.lu_issue = 0;
        #3;
        chk("rt_haz_c1", 32'(bus.hazard), 1);
        @(negedge clk);
        @(negedge clk);
        bus.lu_valid = 1;
        bus.lu_rd = 7;
        bus.lu_data = 32'h1234;
        #3;
        chk("rt_no_fallthrough", 32'(bus.rf_we), 0);
        @(negedge clk);
        bus.lu_valid = 0;
        #3;
        chk("rt_we_c4", 32'(bus.rf_we), 1);
        chk("rt_addr_c4", 32'(bus.rf_addr), 7);
        chk("rt_data_c4", bus.rf_data, 32'h1234);
        chk("rt_haz_c4", 32'(bus.hazard), 1);
        @(negedge clk);
        #3;
        chk("rt_haz_c5", 32'(bus.hazard), 0);
        // contention: busy pipeline, three back-to-back LU results
        issue(10);
        issue(11);
        issue(12);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            idle();
            bus.pipe_addr = 20;
            bus.pipe_data = 32'(c);
            bus.pipe_we = !bus.pipe_stall;
            bus.lu_valid = idx < 3;
            bus.lu_rd = 5'(10 + idx);
            bus.lu_data = 32'(32'h100 + idx);
            #3;
            if (c == 2) chk("cont_ready_c2", 32'(bus.lu_ready), 0);
            if (c == 4) chk("cont_stall_c4", 32'(bus.pipe_stall), 0);
            if (c == 5) begin
                chk("cont_stall_c5", 32'(bus.pipe_stall), 1);
                chk("cont_we_c5", 32'(bus.rf_we), 1);
                chk("cont_addr_c5", 32'(bus.rf_addr), 10);
                chk("cont_data_c5", bus.rf_data, 32'h100);
            end
            if (bus.lu_valid && bus.lu_ready) idx++;
        end
        repeat (4) begin
            @(negedge clk);
            idle();
        end
        bus.dec_rs1 = 10;
        bus.dec_rs2 = 11;
        bus.dec_rd = 12;
        #3;
        chk("cont_drained_haz", 32'(bus.hazard), 0);
        chk("cont_err", 32'(bus.err), 0);
        // simultaneous set/clear of rd=9
        issue(9);
        bus.dec_rs1 = 9;
        @(negedge clk);
        bus.lu_issue = 0;
        bus.lu_valid = 1;
        bus.lu_rd = 9;
        bus.lu_data = 32'h99;
        @(negedge clk);
        bus.lu_valid = 0;
        bus.lu_issue = 1;
        bus.lu_issue_rd = 9;
        #3;
        chk("sc_we", 32'(bus.rf_we), 1);
        chk("sc_addr", 32'(bus.rf_addr), 9);
        @(negedge clk);
        bus.lu_issue = 0;
        bus.lu_valid = 1;
        bus.lu_data = 32'h98;
        #3;
        chk("sc_haz_held", 32'(bus.hazard), 1);
        @(negedge clk);
        bus.lu_valid = 0;
        @(negedge clk);
        #3;
        chk("sc_haz_cleared", 32'(bus.hazard), 0);
        chk("sc_err", 32'(bus.err), 0);
        // LU write to non-pending rd=3
        @(negedge clk);
        idle();
        bus.lu_valid = 1;
        bus.lu_rd = 3;
        bus.lu_data = 32'h3;
        @(negedge clk);
        bus.lu_valid = 0;
        #3;
        chk("np_addr", 32'(bus.rf_addr), 3);
        chk("np_err_before", 32'(bus.err), 0);
        @(negedge clk);
        #3;
        chk("np_err_set", 32'(bus.err), 1);
        repeat (3) @(negedge clk);
        #3;
        chk("np_err_held", 32'(bus.err), 1);
        rst_pulse();
        #3;
        chk("np_err_rst", 32'(bus.err), 0);
        // pipeline write during stall
        issue(13);
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            idle();
            bus.pipe_we = 1;
            bus.pipe_addr = 21;
            bus.pipe_data = 32'(e);
            bus.lu_valid = e == 0;
            bus.lu_rd = 13;
            bus.lu_data = 32'h13;
            #3;
            if (e == 5) begin
                chk("drop_stall", 32'(bus.pipe_stall), 1);
                chk("drop_addr", 32'(bus.rf_addr), 13);
                chk("drop_data", bus.rf_data, 32'h13);
                chk("drop_err_before", 32'(bus.err), 0);
            end
            if (e == 6) chk("drop_err_set", 32'(bus.err), 1);
        end
        rst_pulse();
        // reset with two buffered entries and pend bits set
        issue(14);
        issue(15);
        issue(16);
        bus.pipe_we = 1;
        bus.pipe_addr = 22;
        bus.lu_valid = 1;
        bus.lu_rd = 14;
        bus.lu_data = 32'h14;
        @(negedge clk);
        bus.lu_issue = 0;
        bus.lu_rd = 15;
        bus.lu_data = 32'h15;
        @(negedge clk);
        bus.lu_valid = 0;
        bus.dec_rs1 = 14;
        bus.dec_rs2 = 15;
        bus.dec_rd = 16;
        #3;
        chk("mid_ready_full", 32'(bus.lu_ready), 0);
        chk("mid_haz", 32'(bus.hazard), 1);
        @(negedge clk);
        bus.pipe_we = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #3;
        chk("mid_rf_we", 32'(bus.rf_we), 0);
        chk("mid_haz_rst", 32'(bus.hazard), 0);
        chk("mid_ready_rst", 32'(bus.lu_ready), 1);
        repeat (5) @(negedge clk);
        #3;
        chk("mid_no_stale", 32'(bus.rf_we), 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
